// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 CTR engine: block/key widths, FSM state
// encoding and the masked counter increment.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Increments only the low ctr_w bits modulo 2^ctr_w; the upper bits are untouched.
  function automatic logic [AES_BLK_W-1:0] ctr_inc(input logic [AES_BLK_W-1:0] ctr,
                                                   input int                   ctr_w);
    logic [AES_BLK_W-1:0] mask;
    mask    = {AES_BLK_W{1'b1}} >> (AES_BLK_W - ctr_w);
    ctr_inc = (ctr & ~mask) | ((ctr + AES_BLK_W'(1)) & mask);
  endfunction

endpackage

// File: rtl/aes128_ctr_engine_if.sv
// Block stream into and out of the CTR engine: input valid/ready/data/last and
// the registered result stream with its own valid/ready.
interface aes128_ctr_engine_if;
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [AES_BLK_W-1:0] in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;
  logic                 out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/aes128_ctr_engine.sv
// CTR-mode sequencer around an external AES128_top core; same path encrypts and decrypts.
// Define AES_CTR_TIMEOUT_EN to build the core-done watchdog and the sticky err flag.
module aes128_ctr_engine
  import aes_pkg::*;
#(
  parameter int CTR_W       = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [AES_KEY_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  aes128_ctr_engine_if.slave   s,
  output logic                 busy,
  output logic [CNT_W-1:0]     blk_count,
  output logic                 aes_start,
  output logic [AES_BLK_W-1:0] aes_datain,
  output logic [AES_KEY_W-1:0] aes_cipherkey,
  input  logic [AES_BLK_W-1:0] aes_dataout,
  input  logic                 aes_done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_OUT   = OUT;

  if (CTR_W < 8 || CTR_W > AES_BLK_W || CNT_W < 1 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("aes128_ctr_engine: parameter out of range");
  end

  logic [1:0]           state_q,      state_d;
  logic                 configured_q, configured_d;
  logic [AES_KEY_W-1:0] key_q,        key_d;
  logic [AES_BLK_W-1:0] ctr_q,        ctr_d;
  logic [AES_BLK_W-1:0] data_q,       data_d;
  logic                 last_q,       last_d;
  logic [AES_BLK_W-1:0] out_data_q,   out_data_d;
  logic                 out_last_q,   out_last_d;
  logic                 out_valid_q,  out_valid_d;
  logic [CNT_W-1:0]     blk_count_q,  blk_count_d;
  logic                 in_ready_w;
  logic                 timeout_w;

  // cfg_load wins over an accept in the same cycle, so ready drops while loading.
  assign in_ready_w    = (state_q == S_IDLE) && configured_q && !cfg_load;
  assign s.in_ready    = in_ready_w;
  assign s.out_valid   = out_valid_q;
  assign s.out_data    = out_data_q;
  assign s.out_last    = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign blk_count     = blk_count_q;
  assign aes_start     = (state_q == S_START);
  assign aes_datain    = ctr_q;
  assign aes_cipherkey = key_q;

`ifdef AES_CTR_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q,  err_d;

  assign timeout_w = (state_q == S_WAIT) && !aes_done && (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));
  assign err       = err_q;

  always_comb begin
    wdog_d = '0;
    err_d  = err_q;
    if (state_q == S_WAIT) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
    if (timeout_w) begin
      err_d = 1'b1;
    end else if (cfg_load && state_q == S_IDLE) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
`else
  assign timeout_w = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    configured_d = configured_q;
    key_d        = key_q;
    ctr_d        = ctr_q;
    data_d       = data_q;
    last_d       = last_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    blk_count_d  = blk_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          key_d        = cfg_key;
          ctr_d        = cfg_iv;
          blk_count_d  = '0;
          configured_d = 1'b1;
        end else if (s.in_valid && in_ready_w) begin
          data_d  = s.in_data;
          last_d  = s.in_last;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (aes_done) begin
          out_data_d  = data_q ^ aes_dataout;
          out_last_d  = last_q;
          out_valid_d = 1'b1;
          ctr_d       = ctr_inc(ctr_q, CTR_W);
          blk_count_d = blk_count_q + CNT_W'(1);
          state_d     = S_OUT;
        end else if (timeout_w) begin
          // The block is dropped; the engine must be re-keyed before accepting again.
          configured_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_OUT: begin
        if (s.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      configured_q <= 1'b0;
      key_q        <= '0;
      ctr_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      configured_q <= configured_d;
      key_q        <= key_d;
      ctr_q        <= ctr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      blk_count_q  <= blk_count_d;
    end
  end

endmodule
